// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//
// Purpose:
//   Shared definitions for the pipeline-control blocks. The first user is
//   pipe_skid_reg, the elastic register placed between two CPU stages.
//   Future hazard/stall blocks are meant to import the same encodings.
//
// Contents:
//   pipe_state_e   - occupancy state of a two-entry skid register
//   PIPE_MAX_SIZE  - widest bundle a pipeline register is expected to carry
//   pipe_size_ok() - helper telling whether a bundle width is in range
// ---------------------------------------------------------------------------
package pipe_pkg;

  // Occupancy of a skid register. The encodings are fixed because other
  // blocks may decode them directly from a debug or status bus.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // Upper bound on the width of a pipeline bundle.
  localparam int PIPE_MAX_SIZE = 256;

  // True when a bundle width lies in 1..PIPE_MAX_SIZE.
  function automatic bit pipe_size_ok(input int width);
    return (width >= 1) && (width <= PIPE_MAX_SIZE);
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// ---------------------------------------------------------------------------
// pipe_skid_entry
//
// Purpose:
//   One storage slot of the skid register. It holds a bundle of 'size' bits
//   with a load enable and a synchronous clear. Clear wins over load, so a
//   reset or flush on the same edge as a load always leaves the slot at zero.
//
// Ports:
//   clk_i  in   1     clock, rising edge
//   clear  in   1     synchronous clear to all zeros
//   load   in   1     capture d on this edge
//   d      in   size  next value
//   q      out  size  stored value
// ---------------------------------------------------------------------------
module pipe_skid_entry #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            clear,
  input  logic            load,
  input  logic [size-1:0] d,
  output logic [size-1:0] q
);

  // Storage flops. Clear takes priority so that the slot reads as a bubble
  // (all zeros) after reset or flush, whatever the handshake was doing.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//
// Purpose:
//   Elastic pipeline register between two CPU stages using a valid/ready
//   handshake on both sides. It has two entries, main and skid, so that it
//   can keep one transfer per cycle while the downstream ready is only seen
//   through flops: in_ready_o comes straight from a register and never from
//   out_ready_i combinationally. Bundles leave in strict FIFO order, one
//   cycle after they are accepted when the register is not stalled.
//
// Ports:
//   clk_i        in   1     clock, rising edge
//   rst_i        in   1     synchronous reset, active high
//   flush_i      in   1     synchronous squash (only with PIPE_SKID_REG_FLUSH_EN)
//   in_valid_i   in   1     upstream bundle on in_data_i is valid
//   in_data_i    in   size  upstream bundle
//   in_ready_o   out  1     register can accept (flop output)
//   out_valid_o  out  1     out_data_o holds a valid bundle (flop output)
//   out_data_o   out  size  downstream bundle, taken from the main entry
//   out_ready_i  in   1     downstream accepts this cycle
//
// Build option:
//   PIPE_SKID_REG_FLUSH_EN - when defined, adds flush_i for branch-taken
//   squash. Flush empties both entries to zero and discards any transfer
//   accepted on the same edge. Priority is rst_i > flush_i > handshake.
// ---------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
`ifdef PIPE_SKID_REG_FLUSH_EN
  input  logic            flush_i,
`endif
  input  logic            in_valid_i,
  input  logic [size-1:0] in_data_i,
  output logic            in_ready_o,
  output logic            out_valid_o,
  output logic [size-1:0] out_data_o,
  input  logic            out_ready_i
);

  pipe_state_e     state;
  logic            in_ready_q;
  logic            out_valid_q;

  logic            flush;
  logic            in_fire;
  logic            out_fire;
  logic            entry_clear;

  logic            main_load;
  logic            main_from_skid;
  logic            skid_load;
  logic [size-1:0] main_d;
  logic [size-1:0] main_q;
  logic [size-1:0] skid_q;

`ifdef PIPE_SKID_REG_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Both handshakes use only flopped outputs of this block, so neither fire
  // term creates a combinational ready path through the register.
  assign in_fire     = in_valid_i && in_ready_q;
  assign out_fire    = out_valid_q && out_ready_i;
  assign entry_clear = rst_i || flush;

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;

  // Datapath steering. The main entry is loaded from the input when it is
  // free or being drained in the same cycle, and from the skid entry when a
  // full register drains. The skid entry only captures when the main entry
  // is occupied and stalled. A FULL register cannot see in_fire because
  // in_ready is low there, so that case needs no handling.
  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      ST_EMPTY: begin
        main_load = in_fire;
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign main_d = main_from_skid ? skid_q : in_data_i;

  // Occupancy FSM with its two handshake outputs kept in flops next to the
  // state. Reset and flush both return to EMPTY with ready high. The unused
  // encoding falls back to EMPTY so the register recovers on its own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state       <= ST_BUSY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && !out_fire) begin
            state       <= ST_FULL;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else if (!in_fire && out_fire) begin
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state       <= ST_BUSY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Main entry: always the entry presented downstream.
  pipe_skid_entry #(
    .size (size)
  ) u_main (
    .clk_i (clk_i),
    .clear (entry_clear),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  // Skid entry: catches the bundle that arrives in the cycle the
  // downstream stalls, since in_ready only drops one edge later.
  pipe_skid_entry #(
    .size (size)
  ) u_skid (
    .clk_i (clk_i),
    .clear (entry_clear),
    .load  (skid_load),
    .d     (in_data_i),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Directed bench for pipe_skid_reg with size = 8. Accepted bundles are
// pushed to a scoreboard queue at the input handshake and popped and
// compared at the output handshake. Inputs change after the falling edge
// and outputs are sampled there too. With PIPE_SKID_REG_FLUSH_EN defined
// the flush steps are included as well.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int W = 8;

  logic         clk;
  logic         rst;
`ifdef PIPE_SKID_REG_FLUSH_EN
  logic         flush;
`endif
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] expected;

  pipe_skid_reg #(
    .size (W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
`ifdef PIPE_SKID_REG_FLUSH_EN
    .flush_i     (flush),
`endif
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] required);
    checks++;
    assert (observed === required) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, required);
    end
  endtask

  // Drive inputs for the coming edge (called just after a falling edge).
  task automatic applyStimulus(input logic v, input logic [W-1:0] d,
                               input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // Advance one clock. Handshakes are resolved from the driven inputs and
  // the flopped outputs before the edge; outgoing bundles are checked
  // against the scoreboard and incoming ones are recorded.
  task automatic tick();
    logic squash;
    squash = rst;
`ifdef PIPE_SKID_REG_FLUSH_EN
    squash = squash || flush;
`endif
    if (!squash) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", {24'd0, out_data}, 32'hDEAD);
        end else begin
          expected = exp_q.pop_front();
          checkOutput("scoreboard_data", {24'd0, out_data}, {24'd0, expected});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
    @(posedge clk);
    @(negedge clk);
    if (squash) exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
`ifdef PIPE_SKID_REG_FLUSH_EN
    flush = 1'b0;
`endif
    applyStimulus(1'b1, 8'hAA, 1'b0);
    @(negedge clk);

    // Reset held two cycles with traffic offered.
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_out_data", {24'd0, out_data}, 32'h00);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming 0x01..0x10 with downstream always ready.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, W'(i), 1'b1);
      tick();
      checkOutput("stream_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stream_latency", {24'd0, out_data}, i);
      checkOutput("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("stream_empty", {31'd0, out_valid}, 32'd0);

    // Stall fill: 0x11 then 0x22 with downstream stalled.
    applyStimulus(1'b1, 8'h11, 1'b0);
    tick();
    checkOutput("fill_first_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 8'h22, 1'b0);
    tick();
    checkOutput("fill_full_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h33, 1'b0);
      tick();
      checkOutput("stall_data", {24'd0, out_data}, 32'h11);
      checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_ready", {31'd0, in_ready}, 32'd0);
    end
    checkOutput("stall_queue_depth", exp_q.size(), 32'd2);

    // Drain 0x11 then 0x22.
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("drain1_data", {24'd0, out_data}, 32'h22);
    checkOutput("drain1_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("drain2_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("drain_queue_empty", exp_q.size(), 32'd0);

    // Simultaneous in/out fire in BUSY.
    applyStimulus(1'b1, 8'h44, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h55, 1'b1);
    tick();
    checkOutput("simul_data", {24'd0, out_data}, 32'h55);
    checkOutput("simul_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("simul_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("simul_drain_valid", {31'd0, out_valid}, 32'd0);

    // Reset while FULL discards both entries.
    applyStimulus(1'b1, 8'h77, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h88, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_data", {24'd0, out_data}, 32'h00);
    checkOutput("midrst_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("midrst_stays_empty", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_REG_FLUSH_EN
    // Flush from FULL with 0x66 offered.
    applyStimulus(1'b1, 8'h99, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hAB, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h66, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_data", {24'd0, out_data}, 32'h00);
    checkOutput("flush_ready", {31'd0, in_ready}, 32'd1);
    // Flush from BUSY with a concurrent accepted transfer of 0x66.
    applyStimulus(1'b1, 8'hCD, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h66, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("flush_no_66_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("flush_no_66_data", {24'd0, out_data}, 32'h00);
      tick();
    end
`endif

    checkOutput("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Elastic pipeline register between two CPU pipeline stages, using a valid/ready handshake on each side.
- Carries one stage's bundle (control plus data, packed into `size` bits) to the next stage.
- Downstream stages can stall (the load-use hazard unit and multi-cycle units) without a combinational ready path crossing the register.
- Two entries, main and skid; full throughput of one transfer per cycle; fixed 1-cycle latency when unstalled.

Parameters:
- size, 32: width of the data bundle in bits; legal range 1..256.

Ports:
- clk_i  input  1  clock; everything is updated on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- in_valid_i  input  1  upstream has valid data on in_data_i.
- in_data_i  input  size  upstream bundle.
- in_ready_o  output  1  register can accept; driven directly from a flop.
- out_valid_o  output  1  out_data_o holds valid data.
- out_data_o  output  size  downstream bundle; driven directly from the main entry flops.
- out_ready_i  input  1  downstream accepts this cycle.

Behaviour:
- Interface decision: one clock (clk_i); reset rst_i is synchronous and active-high.
- Transfer rules:
  - in_fire = in_valid_i && in_ready_o.
  - out_fire = out_valid_o && out_ready_i.
  - Both are evaluated at the rising edge.
- State machine (2-bit):
  - EMPTY: nothing held.
  - BUSY: main entry valid.
  - FULL: main and skid entries both valid.
- Outputs:
  - out_valid_o = (state != EMPTY).
  - in_ready_o = (state != FULL), held in its own flop.
  - out_data_o = main entry.
- Transitions:
  - EMPTY, in_fire: main <= in_data_i; go to BUSY.
  - BUSY, in_fire and out_fire: main <= in_data_i; stay in BUSY.
  - BUSY, in_fire only: skid <= in_data_i; go to FULL.
  - BUSY, out_fire only: go to EMPTY; main keeps its old value.
  - FULL, out_fire: main <= skid; go to BUSY. in_fire is impossible because in_ready_o = 0.
  - Any state, no fire: hold everything.
- Ordering: strict FIFO. No bundle is dropped, duplicated or reordered.
- Latency: a bundle accepted at edge N appears on out_data_o after edge N, when state was EMPTY or BUSY with out_fire.
- Reset (rst_i = 1 at an edge), whatever the current state:
  - state <= EMPTY; out_valid_o = 0; in_ready_o = 1.
  - main and skid <= 0, so out_data_o = 0.
  - in_valid_i and out_ready_i are ignored on that edge.
  - Reset mid-stall discards both entries.
- in_data_i is sampled only on in_fire. out_data_o is stable while out_valid_o = 1 and out_ready_i = 0.
- out_valid_o never deasserts without an out_fire, except on reset or flush.
- Upstream may drop in_valid_i while in_ready_o = 0 (no obligation to hold).

Optional Feature:
- Macro: PIPE_SKID_REG_FLUSH_EN.
- Defined:
  - Adds input port flush_i (1 bit), placed after rst_i.
  - flush_i = 1 at an edge: state <= EMPTY; main and skid <= 0 (bubble/NOP); in_ready_o <= 1. A concurrent in_fire is discarded.
  - Priority: rst_i > flush_i > handshake.
  - Used for branch-taken squash.
- Undefined: the flush_i port does not exist and behaviour is as above.

Decomposition:
- Package pipe_pkg:
  - State encodings ST_EMPTY = 2'd0, ST_BUSY = 2'd1, ST_FULL = 2'd2.
  - PIPE_MAX_SIZE = 256.
  - Shared with future pipeline-control blocks.
- One natural sub-module: pipe_skid_entry.
  - A size-bit register with load enable and synchronous clear.
  - Instantiated twice, for main and skid.
- The FSM stays in pipe_skid_reg.

Test Plan (size = 8):
- Reset:
  - Stimulus: hold rst_i for 2 cycles with in_valid_i = 1, in_data_i = 8'hAA.
  - Required: out_valid_o = 0, out_data_o = 8'h00, in_ready_o = 1 after the reset edges.
- Streaming:
  - Stimulus: out_ready_i = 1; feed 8'h01..8'h10 with in_valid_i continuously high.
  - Required: each value appears one cycle after acceptance, in order; in_ready_o never drops.
- Stall fill:
  - Stimulus: out_ready_i = 0; send 8'h11, then 8'h22.
  - Required: in_ready_o = 0 after the second edge. out_data_o = 8'h11 holds stable for 5 stalled cycles. An 8'h33 offered meanwhile is not accepted.
- Drain:
  - Stimulus: from FULL (8'h11, 8'h22), raise out_ready_i with in_valid_i = 0.
  - Required: 8'h11 is taken, then 8'h22, then out_valid_o = 0. in_ready_o = 1 after the first drain edge.
- Simultaneous:
  - Stimulus: in BUSY holding 8'h44, in_fire and out_fire with 8'h55 in the same cycle.
  - Required: out_data_o = 8'h55; state stays BUSY.
- Flush (macro defined):
  - Stimulus: in FULL, pulse flush_i with in_valid_i = 1, in_data_i = 8'h66.
  - Required: next cycle out_valid_o = 0, out_data_o = 8'h00, in_ready_o = 1; 8'h66 is never seen on the output.
